// File: rtl/weight_medium_pkg.sv
// Shared types for the weight-medium arbiter.
//   state_e : arbiter FSM states (IDLE, ISSUE, READ_WAIT)
//   req_e   : requester identity (CPU, host loader)
//   op_e    : captured operation (read, write)
//   rr_pick : round-robin choice between the two requesters
package weight_medium_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        READ_WAIT
    } state_e;

    typedef enum logic {
        REQ_CPU,
        REQ_HOST
    } req_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

    // Single pending side wins outright; on a tie the side that was not
    // granted last wins.
    function automatic req_e rr_pick(input logic cpu_valid,
                                     input logic host_valid,
                                     input req_e last_grant);
        if (cpu_valid && host_valid)
            return (last_grant == REQ_HOST) ? REQ_CPU : REQ_HOST;
        else if (cpu_valid)
            return REQ_CPU;
        else
            return REQ_HOST;
    endfunction

endpackage

// File: rtl/medium_request_slot.sv
// One-entry request holder for a single requester.
//   clk_in, rst_in            : clock, synchronous active-low reset
//   read_en_in, write_en_in   : one-cycle request pulses (both = write)
//   addr_in, data_in          : request address / write data
//   clear_in                  : request completes on this edge
//   valid_out, op_out,
//   addr_out, data_out        : the pending request
//   overrun_out               : sticky, a pulse arrived while busy
module medium_request_slot
    import weight_medium_pkg::*;
#(
    parameter int A_SIZE = 8,
    parameter int W_SIZE = 1024
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              read_en_in,
    input  logic              write_en_in,
    input  logic [A_SIZE-1:0] addr_in,
    input  logic [W_SIZE-1:0] data_in,
    input  logic              clear_in,
    output logic              valid_out,
    output op_e               op_out,
    output logic [A_SIZE-1:0] addr_out,
    output logic [W_SIZE-1:0] data_out,
    output logic              overrun_out
);

    logic              valid_q, valid_d;
    op_e               op_q, op_d;
    logic [A_SIZE-1:0] addr_q, addr_d;
    logic [W_SIZE-1:0] data_q, data_d;
    logic              overrun_q, overrun_d;
    logic              pulse;

    assign pulse = read_en_in | write_en_in;

    // NOTE: every always_comb output gets a hold default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        valid_d   = valid_q;
        op_d      = op_q;
        addr_d    = addr_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        // A slot that completes on this edge is free again, so a pulse
        // landing on the same edge refills it instead of being dropped.
        if (pulse && valid_q && !clear_in) begin
            overrun_d = 1'b1;
        end else if (pulse) begin
            valid_d = 1'b1;
            op_d    = write_en_in ? OP_WRITE : OP_READ;
            addr_d  = addr_in;
            data_d  = data_in;
        end else if (clear_in) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q   <= 1'b0;
            op_q      <= OP_READ;
            addr_q    <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid_out   = valid_q;
    assign op_out      = op_q;
    assign addr_out    = addr_q;
    assign data_out    = data_q;
    assign overrun_out = overrun_q;

endmodule

// File: rtl/weight_medium_arbiter.sv
// Shares the single-port weight BRAM between the CPU weight-medium port and
// the host loader port, one access in flight at a time.
//   clk_in, rst_in                 : clock, synchronous active-low reset
//   cpu_* / host_* inputs          : address, write data, read/write pulses
//   cpu_data_out / host_data_out   : last successful read per side
//   cpu_finished_out / host_...    : one-cycle completion pulse per request
//   cpu_overrun_out / host_...     : sticky dropped-pulse flags
//   bram_*                         : registered BRAM port, bram_data_in = read data
module weight_medium_arbiter
    import weight_medium_pkg::*;
#(
    parameter int WEIGHT_LENGTH = 256,
    parameter int W_SIZE        = 1024,
    parameter int READ_LATENCY  = 2,
    parameter int A_SIZE        = $clog2(WEIGHT_LENGTH)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [A_SIZE-1:0] cpu_addr_in,
    input  logic [W_SIZE-1:0] cpu_data_in,
    input  logic              cpu_read_enable_in,
    input  logic              cpu_write_enable_in,
    output logic [W_SIZE-1:0] cpu_data_out,
    output logic              cpu_finished_out,
    input  logic [A_SIZE-1:0] host_addr_in,
    input  logic [W_SIZE-1:0] host_data_in,
    input  logic              host_read_enable_in,
    input  logic              host_write_enable_in,
    output logic [W_SIZE-1:0] host_data_out,
    output logic              host_finished_out,
    output logic              cpu_overrun_out,
    output logic              host_overrun_out,
    output logic [A_SIZE-1:0] bram_addr_out,
    output logic [W_SIZE-1:0] bram_data_out,
    output logic              bram_en_out,
    output logic              bram_we_out,
    input  logic [W_SIZE-1:0] bram_data_in
);

    localparam int              CNT_W      = $clog2(READ_LATENCY + 1);
    localparam logic [A_SIZE:0] LENGTH_EXT = (A_SIZE + 1)'(WEIGHT_LENGTH);

    function automatic logic in_range(input logic [A_SIZE-1:0] addr);
        return {1'b0, addr} < LENGTH_EXT;
    endfunction

    logic              cpu_valid, host_valid;
    op_e               cpu_op, host_op;
    logic [A_SIZE-1:0] cpu_addr, host_addr;
    logic [W_SIZE-1:0] cpu_wdata, host_wdata;

    state_e            state_q, state_d;
    req_e              grant_q, grant_d;
    req_e              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bram_en_q, bram_en_d;
    logic              bram_we_q, bram_we_d;
    logic [A_SIZE-1:0] bram_addr_q, bram_addr_d;
    logic [W_SIZE-1:0] bram_data_q, bram_data_d;
    logic [W_SIZE-1:0] cpu_dout_q, cpu_dout_d;
    logic [W_SIZE-1:0] host_dout_q, host_dout_d;
    logic              cpu_fin_q, cpu_fin_d;
    logic              host_fin_q, host_fin_d;

    req_e              pick;
    logic [A_SIZE-1:0] pick_addr, g_addr;
    logic [W_SIZE-1:0] pick_data;
    op_e               pick_op, g_op;

    // The finished pulse and the slot clear happen on the same edge.
    medium_request_slot #(.A_SIZE(A_SIZE), .W_SIZE(W_SIZE)) u_cpu_slot (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .read_en_in  (cpu_read_enable_in),
        .write_en_in (cpu_write_enable_in),
        .addr_in     (cpu_addr_in),
        .data_in     (cpu_data_in),
        .clear_in    (cpu_fin_d),
        .valid_out   (cpu_valid),
        .op_out      (cpu_op),
        .addr_out    (cpu_addr),
        .data_out    (cpu_wdata),
        .overrun_out (cpu_overrun_out)
    );

    medium_request_slot #(.A_SIZE(A_SIZE), .W_SIZE(W_SIZE)) u_host_slot (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .read_en_in  (host_read_enable_in),
        .write_en_in (host_write_enable_in),
        .addr_in     (host_addr_in),
        .data_in     (host_data_in),
        .clear_in    (host_fin_d),
        .valid_out   (host_valid),
        .op_out      (host_op),
        .addr_out    (host_addr),
        .data_out    (host_wdata),
        .overrun_out (host_overrun_out)
    );

    assign pick      = rr_pick(cpu_valid, host_valid, last_grant_q);
    assign pick_addr = (pick == REQ_CPU) ? cpu_addr  : host_addr;
    assign pick_data = (pick == REQ_CPU) ? cpu_wdata : host_wdata;
    assign pick_op   = (pick == REQ_CPU) ? cpu_op    : host_op;
    // The granted slot cannot be overwritten until it completes, so its
    // fields stay valid for the whole access.
    assign g_addr    = (grant_q == REQ_CPU) ? cpu_addr : host_addr;
    assign g_op      = (grant_q == REQ_CPU) ? cpu_op   : host_op;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        bram_en_d    = 1'b0;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_data_d  = bram_data_q;
        cpu_dout_d   = cpu_dout_q;
        host_dout_d  = host_dout_q;
        cpu_fin_d    = 1'b0;
        host_fin_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_valid || host_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    bram_addr_d  = pick_addr;
                    bram_data_d  = pick_data;
                    // Out-of-range requests walk through ISSUE without
                    // touching the BRAM.
                    bram_en_d    = in_range(pick_addr);
                    bram_we_d    = in_range(pick_addr) && (pick_op == OP_WRITE);
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (g_op == OP_WRITE || !in_range(g_addr)) begin
                    cpu_fin_d  = (grant_q == REQ_CPU);
                    host_fin_d = (grant_q == REQ_HOST);
                    state_d    = IDLE;
                end else begin
                    cnt_d   = CNT_W'(READ_LATENCY);
                    state_d = READ_WAIT;
                end
            end
            READ_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (grant_q == REQ_CPU) begin
                        cpu_dout_d = bram_data_in;
                        cpu_fin_d  = 1'b1;
                    end else begin
                        host_dout_d = bram_data_in;
                        host_fin_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            grant_q      <= REQ_CPU;
            last_grant_q <= REQ_HOST;
            cnt_q        <= '0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_data_q  <= '0;
            cpu_dout_q   <= '0;
            host_dout_q  <= '0;
            cpu_fin_q    <= 1'b0;
            host_fin_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_data_q  <= bram_data_d;
            cpu_dout_q   <= cpu_dout_d;
            host_dout_q  <= host_dout_d;
            cpu_fin_q    <= cpu_fin_d;
            host_fin_q   <= host_fin_d;
        end
    end

    assign bram_en_out       = bram_en_q;
    assign bram_we_out       = bram_we_q;
    assign bram_addr_out     = bram_addr_q;
    assign bram_data_out     = bram_data_q;
    assign cpu_data_out      = cpu_dout_q;
    assign host_data_out     = host_dout_q;
    assign cpu_finished_out  = cpu_fin_q;
    assign host_finished_out = host_fin_q;

endmodule

// File: tb/tb_weight_medium_arbiter.sv
// Bench for weight_medium_arbiter. WEIGHT_LENGTH is 200 so that an 8-bit
// address can name words past the end of the array.
module tb_weight_medium_arbiter;

    localparam int WL = 200;
    localparam int WS = 1024;
    localparam int RL = 2;
    localparam int AS = $clog2(WL);

    logic          clk = 1'b0;
    logic          rst_in;
    logic [AS-1:0] cpu_addr_in, host_addr_in;
    logic [WS-1:0] cpu_data_in, host_data_in;
    logic          cpu_read_enable_in, cpu_write_enable_in;
    logic          host_read_enable_in, host_write_enable_in;
    logic [WS-1:0] cpu_data_out, host_data_out;
    logic          cpu_finished_out, host_finished_out;
    logic          cpu_overrun_out, host_overrun_out;
    logic [AS-1:0] bram_addr_out;
    logic [WS-1:0] bram_data_out, bram_data_in;
    logic          bram_en_out, bram_we_out;

    always #5 clk = ~clk;

    weight_medium_arbiter #(.WEIGHT_LENGTH(WL), .W_SIZE(WS), .READ_LATENCY(RL)) dut (
        .clk_in               (clk),
        .rst_in               (rst_in),
        .cpu_addr_in          (cpu_addr_in),
        .cpu_data_in          (cpu_data_in),
        .cpu_read_enable_in   (cpu_read_enable_in),
        .cpu_write_enable_in  (cpu_write_enable_in),
        .cpu_data_out         (cpu_data_out),
        .cpu_finished_out     (cpu_finished_out),
        .host_addr_in         (host_addr_in),
        .host_data_in         (host_data_in),
        .host_read_enable_in  (host_read_enable_in),
        .host_write_enable_in (host_write_enable_in),
        .host_data_out        (host_data_out),
        .host_finished_out    (host_finished_out),
        .cpu_overrun_out      (cpu_overrun_out),
        .host_overrun_out     (host_overrun_out),
        .bram_addr_out        (bram_addr_out),
        .bram_data_out        (bram_data_out),
        .bram_en_out          (bram_en_out),
        .bram_we_out          (bram_we_out),
        .bram_data_in         (bram_data_in)
    );

    // BRAM with two-cycle read latency; 2-state storage starts at zero.
    bit [WS-1:0] bram_mem [WL];
    bit [WS-1:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (bram_en_out) begin
            if (bram_we_out) bram_mem[bram_addr_out] <= bram_data_out;
            rd_p1 <= bram_mem[bram_addr_out];
        end
        rd_p2 <= rd_p1;
    end
    assign bram_data_in = rd_p2;

    // Transaction-level reference: index 0 = CPU, 1 = host. A grant at edge
    // G completes at G+1 (write / out of range) or G+1+RL (read); the arbiter
    // is free again only on the edge after completion.
    int          checks = 0;
    int          errors = 0;
    int          n = 0;
    bit          m_pv [2];
    bit          m_pw [2];
    int          m_pa [2];
    logic [WS-1:0] m_pd [2];
    logic [WS-1:0] m_dout [2];
    bit          m_ovr [2];
    bit          m_fin [2];
    bit          m_busy, m_rd, m_en, m_we;
    int          m_who, m_last, m_done_at, m_addr;
    logic [WS-1:0] m_rdval, m_data;
    bit [WS-1:0] m_mem [WL];

    task automatic check(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
        int k;
        checks++;
        if (got !== exp) begin
            errors++;
            k = 0;
            for (int i = WS - 1; i >= 0; i--) if (got[i] !== exp[i]) k = i;
            k = (k / 64) * 64;
            $display("FAIL %s edge %0d: got[%0d+:64]=%h expected %h",
                     tag, n, k, got[k +: 64], exp[k +: 64]);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_pv[s] = 0; m_dout[s] = '0; m_ovr[s] = 0; m_fin[s] = 0;
        end
        m_busy = 0; m_last = 1; m_en = 0; m_we = 0;
    endtask

    task automatic model_step();
        bit            re [2];
        bit            we [2];
        int            a  [2];
        logic [WS-1:0] d  [2];
        n++;
        m_fin[0] = 0; m_fin[1] = 0; m_en = 0; m_we = 0;
        if (!rst_in) begin
            model_reset();
            return;
        end
        re[0] = cpu_read_enable_in;  we[0] = cpu_write_enable_in;
        re[1] = host_read_enable_in; we[1] = host_write_enable_in;
        a[0] = int'(cpu_addr_in);    a[1] = int'(host_addr_in);
        d[0] = cpu_data_in;          d[1] = host_data_in;

        if (m_busy && n == m_done_at) begin
            m_fin[m_who] = 1;
            if (m_rd) m_dout[m_who] = m_rdval;
            m_pv[m_who] = 0;
            m_busy = 0;
        end else if (!m_busy && (m_pv[0] || m_pv[1])) begin
            if (m_pv[0] && m_pv[1]) m_who = (m_last == 1) ? 0 : 1;
            else                    m_who = m_pv[0] ? 0 : 1;
            m_last = m_who;
            m_busy = 1;
            m_rd   = 0;
            m_addr = m_pa[m_who];
            m_data = m_pd[m_who];
            if (m_addr >= WL) begin
                m_done_at = n + 1;
            end else if (m_pw[m_who]) begin
                m_en = 1; m_we = 1;
                m_mem[m_addr] = m_data;
                m_done_at = n + 1;
            end else begin
                m_en = 1;
                m_rd = 1;
                m_rdval = m_mem[m_addr];
                m_done_at = n + 1 + RL;
            end
        end

        for (int s = 0; s < 2; s++) begin
            if (re[s] || we[s]) begin
                if (m_pv[s]) m_ovr[s] = 1;
                else begin
                    m_pv[s] = 1; m_pw[s] = we[s]; m_pa[s] = a[s]; m_pd[s] = d[s];
                end
            end
        end
    endtask

    task automatic compare();
        check("cpu_finished",  cpu_finished_out,  m_fin[0]);
        check("host_finished", host_finished_out, m_fin[1]);
        check("cpu_data",      cpu_data_out,      m_dout[0]);
        check("host_data",     host_data_out,     m_dout[1]);
        check("cpu_overrun",   cpu_overrun_out,   m_ovr[0]);
        check("host_overrun",  host_overrun_out,  m_ovr[1]);
        check("bram_en",       bram_en_out,       m_en);
        check("bram_we",       bram_we_out,       m_we);
        if (m_en) check("bram_addr", bram_addr_out, m_addr);
        if (m_we) check("bram_wdata", bram_data_out, m_data);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        cpu_read_enable_in  = 0; cpu_write_enable_in  = 0;
        host_read_enable_in = 0; host_write_enable_in = 0;
    endtask

    task automatic pulse(input int side, input bit re, input bit we,
                         input int addr, input logic [WS-1:0] data);
        if (side == 0) begin
            cpu_read_enable_in = re; cpu_write_enable_in = we;
            cpu_addr_in = AS'(addr); cpu_data_in = data;
        end else begin
            host_read_enable_in = re; host_write_enable_in = we;
            host_addr_in = AS'(addr); host_data_in = data;
        end
    endtask

    // Bounded wait: records the first edge each side finishes, -1 if never.
    task automatic run(input int cycles, output int cpu_at, output int host_at, output bit en_seen);
        cpu_at = -1; host_at = -1; en_seen = 0;
        repeat (cycles) begin
            cycle();
            if (cpu_finished_out  && cpu_at  < 0) cpu_at  = n;
            if (host_finished_out && host_at < 0) host_at = n;
            if (bram_en_out) en_seen = 1;
        end
    endtask

    function automatic logic [WS-1:0] rand_word();
        logic [WS-1:0] r;
        for (int i = 0; i < WS / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        int            e0, ca, ha;
        bit            en;
        logic [WS-1:0] a5, keep;
        a5 = {(WS / 8){8'hA5}};
        rst_in = 0;
        pulse(0, 0, 0, 0, '0);
        pulse(1, 0, 0, 0, '0);
        model_reset();
        repeat (3) cycle();
        rst_in = 1;
        cycle();

        // CPU write then read of address 5.
        pulse(0, 0, 1, 5, a5); cycle(); e0 = n;
        run(6, ca, ha, en);
        check("wr_latency", ca - e0, 2);
        pulse(0, 1, 0, 5, '0); cycle(); e0 = n;
        run(8, ca, ha, en);
        check("rd_latency", ca - e0, 4);
        check("rd_a5", cpu_data_out, a5);
        check("host_idle", ha, -1);

        // Seed addresses 1 and 2, then a simultaneous read pair.
        pulse(0, 0, 1, 1, WS'(32'h1111)); cycle(); run(4, ca, ha, en);
        pulse(1, 0, 1, 2, WS'(32'h2222)); cycle(); run(4, ca, ha, en);
        pulse(0, 1, 0, 1, '0); pulse(1, 1, 0, 2, '0); cycle(); e0 = n;
        run(12, ca, ha, en);
        check("tie1_cpu_lat",  ca - e0, 4);
        check("tie1_host_lat", ha - e0, 8);
        check("tie1_cpu_data",  cpu_data_out,  WS'(32'h1111));
        check("tie1_host_data", host_data_out, WS'(32'h2222));
        // A lone CPU access makes the host the next tie winner.
        pulse(0, 1, 0, 5, '0); cycle(); run(6, ca, ha, en);
        pulse(0, 1, 0, 2, '0); pulse(1, 1, 0, 1, '0); cycle(); e0 = n;
        run(12, ca, ha, en);
        check("tie2_host_lat", ha - e0, 4);
        check("tie2_cpu_lat",  ca - e0, 8);

        // Second CPU pulse while the first is still pending.
        pulse(0, 1, 0, 3, '0); cycle();
        pulse(0, 1, 0, 4, '0); cycle();
        check("overrun_set", cpu_overrun_out, 1'b1);
        run(10, ca, ha, en);
        check("overrun_sticky", cpu_overrun_out, 1'b1);

        // Read and write together behaves as a write.
        pulse(0, 1, 1, 9, WS'(8'h3C)); cycle(); run(4, ca, ha, en);
        pulse(0, 1, 0, 9, '0); cycle(); run(6, ca, ha, en);
        check("rw_as_write", cpu_data_out, WS'(8'h3C));

        // Out-of-range address: no BRAM access, data unchanged.
        keep = host_data_out;
        pulse(1, 1, 0, 250, '0); cycle(); e0 = n;
        run(6, ca, ha, en);
        check("oob_latency", ha - e0, 2);
        check("oob_no_en", en, 1'b0);
        check("oob_data_kept", host_data_out, keep);

        // Reset while a read is in READ_WAIT.
        pulse(0, 1, 0, 5, '0); cycle(); cycle(); cycle();
        rst_in = 0; cycle();
        check("rst_cpu_data",  cpu_data_out, '0);
        check("rst_overrun",   cpu_overrun_out, 1'b0);
        check("rst_bram_addr", bram_addr_out, '0);
        check("rst_bram_data", bram_data_out, '0);
        rst_in = 1;
        run(6, ca, ha, en);
        check("rst_no_finish", ca, -1);
        pulse(0, 1, 0, 5, '0); cycle(); e0 = n;
        run(8, ca, ha, en);
        check("post_rst_lat",  ca - e0, 4);
        check("post_rst_data", cpu_data_out, a5);

        // Random traffic from both sides, with one reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(3) == 0) begin
                    int op;
                    int addr;
                    op   = $urandom_range(2);
                    addr = ($urandom_range(9) == 0) ? 200 + $urandom_range(55)
                                                    : $urandom_range(15);
                    pulse(s, op != 1, op != 0, addr, rand_word());
                end
            end
            rst_in = (i != 700);
            cycle();
        end
        rst_in = 1;
        run(10, ca, ha, en);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
